// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared fetch state encoding and default widths
package riscspm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } fetch_state_t;

    localparam int          DEF_ADDR_WIDTH = 8;
    localparam int          DEF_DATA_WIDTH = 16;
    localparam logic [7:0]  DEF_RESET_PC   = 8'h00;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - program memory read bus and decode handshake
interface fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_req;
    logic                  mem_rd_ack;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic [DATA_WIDTH-1:0] memory_data_register;
    logic [ADDR_WIDTH-1:0] program_counter;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  branch_valid;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  halt;
    logic                  halted;
    logic                  fetch_err;

    modport master (
        output mem_addr, mem_rd_req, memory_data_register, program_counter,
               instr_valid, halted, fetch_err,
        input  mem_rd_ack, mem_rd_data, instr_ready, branch_valid,
               branch_target, halt
    );

    modport slave (
        input  mem_addr, mem_rd_req, memory_data_register, program_counter,
               instr_valid, halted, fetch_err,
        output mem_rd_ack, mem_rd_data, instr_ready, branch_valid,
               branch_target, halt
    );
endinterface

// File: rtl/fetch_timeout_timer.sv
// rtl/fetch_timeout_timer.sv - counts unacknowledged request cycles up to a terminal count
module fetch_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // expired flags the cycle that would be the TIMEOUT_CYCLES-th wait
    assign expired = count_en && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, memory read handshake and instruction hold; timeout under FETCH_TIMEOUT_EN
module fetch_sequencer
    import riscspm_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = ADDR_WIDTH'(DEF_RESET_PC),
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    fetch_state_t          state;
    fetch_state_t          state_next;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] mdr;
    logic                  accept;
    logic                  capture;
    logic                  timed_out;

    assign capture = (state == S_REQ) && bus.mem_rd_ack;
    assign accept  = (state == S_HOLD) && bus.instr_ready;

    assign bus.mem_addr             = pc;
    assign bus.program_counter      = pc;
    assign bus.memory_data_register = mdr;
    assign bus.mem_rd_req           = (state == S_REQ);
    assign bus.instr_valid          = (state == S_HOLD);
    assign bus.halted               = (state == S_HALT);

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    fetch_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .count_en ((state == S_REQ) && !bus.mem_rd_ack),
        .clear    (capture),
        .expired  (timed_out)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (timed_out) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
    assign bus.fetch_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_REQ;
            S_REQ: begin
                if (bus.mem_rd_ack)  state_next = S_HOLD;
                else if (timed_out)  state_next = S_HALT;
            end
            S_HOLD: begin
                if (accept)          state_next = bus.halt ? S_HALT : S_REQ;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // branch/halt are only meaningful on the accept cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc  <= RESET_PC;
            mdr <= '0;
        end else begin
            if (capture) mdr <= bus.mem_rd_data;
            if (accept)  pc  <= bus.branch_valid ? bus.branch_target : pc + ADDR_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks against a fetch-order model
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (16),
        .RESET_PC       (8'h10),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prog [256];
    logic [7:0]  exp_pc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one complete fetch: wait, ack, hold, accept; model advances exp_pc
    task automatic fetch_one(input int ack_wait, input int ready_wait,
                             input logic br, input logic [7:0] tgt, input logic hlt);
        logic [15:0] word;
        word = prog[exp_pc];
        for (int i = 0; i < ack_wait; i++) begin
            check("wait_req", 32'(bus.mem_rd_req), 32'd1);
            check("wait_addr", 32'(bus.mem_addr), 32'(exp_pc));
            step();
        end
        check("req", 32'(bus.mem_rd_req), 32'd1);
        check("addr", 32'(bus.mem_addr), 32'(exp_pc));
        bus.mem_rd_ack  = 1'b1;
        bus.mem_rd_data = word;
        step();
        bus.mem_rd_ack  = 1'b0;
        bus.mem_rd_data = 16'(~word);
        check("capture_valid", 32'(bus.instr_valid), 32'd1);
        check("capture_mdr", 32'(bus.memory_data_register), 32'(word));
        for (int i = 0; i < ready_wait; i++) begin
            step();
            check("hold_valid", 32'(bus.instr_valid), 32'd1);
            check("hold_mdr", 32'(bus.memory_data_register), 32'(word));
            check("hold_pc", 32'(bus.program_counter), 32'(exp_pc));
            check("hold_noreq", 32'(bus.mem_rd_req), 32'd0);
        end
        bus.instr_ready   = 1'b1;
        bus.branch_valid  = br;
        bus.branch_target = tgt;
        bus.halt          = hlt;
        step();
        bus.instr_ready  = 1'b0;
        bus.branch_valid = 1'b0;
        bus.halt         = 1'b0;
        exp_pc = br ? tgt : exp_pc + 8'd1;
        check("next_pc", 32'(bus.program_counter), 32'(exp_pc));
        check("next_halted", 32'(bus.halted), 32'(hlt));
        check("next_req", 32'(bus.mem_rd_req), 32'(!hlt));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
        prog[8'h10] = 16'hA5C3;
        bus.mem_rd_ack    = 1'b0;
        bus.mem_rd_data   = 16'h0;
        bus.instr_ready   = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = 8'h00;
        bus.halt          = 1'b0;

        step();
        step();
        check("rst_pc", 32'(bus.program_counter), 32'h10);
        check("rst_mdr", 32'(bus.memory_data_register), 32'h0);
        check("rst_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_err", 32'(bus.fetch_err), 32'd0);

        rst = 1'b1;
        step();
        exp_pc = 8'h10;
        fetch_one(0, 5, 1'b0, 8'h00, 1'b0);
        check("after_first_addr", 32'(bus.mem_addr), 32'h11);

        for (int n = 0; n < 30; n++) begin
            logic       br;
            logic [7:0] tgt;
            br  = ($urandom_range(0, 3) == 0);
            tgt = 8'($urandom);
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), br, tgt, 1'b0);
        end

        // reset lands on an acked request cycle: the ack must be lost
        rst             = 1'b0;
        bus.mem_rd_ack  = 1'b1;
        bus.mem_rd_data = 16'hDEAD;
        step();
        rst            = 1'b1;
        bus.mem_rd_ack = 1'b0;
        check("midrst_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst_req", 32'(bus.mem_rd_req), 32'd0);
        check("midrst_pc", 32'(bus.program_counter), 32'h10);
        check("midrst_mdr", 32'(bus.memory_data_register), 32'h0);
        step();
        check("midrst_rereq", 32'(bus.mem_rd_req), 32'd1);
        check("midrst_addr", 32'(bus.mem_addr), 32'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_noack_valid", 32'(bus.instr_valid), 32'd0);
        end
        exp_pc = 8'h10;

        fetch_one(0, 0, 1'b1, 8'hFF, 1'b0);
        fetch_one(1, 0, 1'b0, 8'h00, 1'b0);
        check("wrap_addr", 32'(bus.mem_addr), 32'h00);

        fetch_one(0, 1, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_noreq", 32'(bus.mem_rd_req), 32'd0);
            check("halt_flag", 32'(bus.halted), 32'd1);
            check("halt_pc", 32'(bus.program_counter), 32'h40);
        end

        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_waiting", 32'(bus.mem_rd_req), 32'd1);
            check("to_err_low", 32'(bus.fetch_err), 32'd0);
        end
        step();
        check("to_err", 32'(bus.fetch_err), 32'd1);
        check("to_halted", 32'(bus.halted), 32'd1);
        check("to_noreq", 32'(bus.mem_rd_req), 32'd0);
`else
        for (int i = 0; i < 100; i++) step();
        check("noto_req", 32'(bus.mem_rd_req), 32'd1);
        check("noto_err", 32'(bus.fetch_err), 32'd0);
        check("noto_halted", 32'(bus.halted), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
